// File: rtl/brent_kung_pipe_adder.sv
// -----------------------------------------------------------------------------
// brent_kung_pipe_adder
//
// Three-stage pipelined Brent-Kung parallel-prefix adder with valid/ready
// flow control.
//
//   Stage 1 register : per-bit generate/propagate (carry-in merged into bit 0)
//   Stage 2 register : result of the up-sweep (log2(WIDTH) levels)
//   Stage 3 register : down-sweep (log2(WIDTH)-1 levels) + sum XOR = outputs
//
// Optional feature macro: BKPA_SUB_EN adds the 'sub' port. With sub=1 the
// beat computes a - b (b inverted, carry-in forced to 1, cin ignored); s[WIDTH]
// is then the "no borrow" flag.
//
// Ports
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat present
//   in_ready   out  block accepts a beat this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in
//   sub        in   subtract select (only with BKPA_SUB_EN)
//   out_valid  out  result beat present
//   out_ready  in   downstream accepts the result
//   s          out  WIDTH+1-bit sum, s[WIDTH] is carry-out
//   ovf        out  two's-complement overflow of s[WIDTH-1:0]
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready. The whole pipeline advances as one (adv = !out_valid ||
// out_ready); in_ready is adv, so an input beat is taken exactly when every
// stage shifts. While out_valid && !out_ready every stage holds its contents.
// -----------------------------------------------------------------------------
module brent_kung_pipe_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef BKPA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             ovf
);

   localparam int LVL = $clog2(WIDTH);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- stage 1: operand conditioning and G/P ------------------
   logic [WIDTH-1:0] b_op;
   logic             c0;
`ifdef BKPA_SUB_EN
   assign b_op = sub ? ~b : b;
   assign c0   = sub | cin;     // subtract forces carry-in to 1
`else
   assign b_op = b;
   assign c0   = cin;
`endif

   logic [WIDTH-1:0] g_in, p_in;
   always_comb begin
      p_in = a ^ b_op;
      g_in = a & b_op;
      // Carry-in is the generate of bit -1; folding it into bit 0 makes every
      // prefix G[i:0] equal G[i:-1], so c[i+1] falls straight out of the tree.
      g_in[0] = (a[0] & b_op[0]) | (p_in[0] & c0);
   end

   logic             s1_v;
   logic [WIDTH-1:0] s1_g, s1_p;
   logic             s1_c0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v  <= 1'b0;
         s1_g  <= '0;
         s1_p  <= '0;
         s1_c0 <= 1'b0;
      end else if (adv) begin
         s1_v  <= in_valid;
         s1_g  <= g_in;
         s1_p  <= p_in;
         s1_c0 <= c0;
      end
   end

   // ---------------- stage 2: up-sweep --------------------------------------
   // Level l combines position i with i-2^(l-1) when (i+1) is a multiple of
   // 2^l. The source position is never itself updated in the same level, so
   // the in-place update is order independent.
   logic [WIDTH-1:0] up_g, up_p;
   always_comb begin
      up_g = s1_g;
      up_p = s1_p;
      for (int l = 1; l <= LVL; l++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (1 << l)) == 0) begin
               up_g[i] = up_g[i] | (up_p[i] & up_g[i - (1 << (l - 1))]);
               up_p[i] = up_p[i] & up_p[i - (1 << (l - 1))];
            end
         end
      end
   end

   logic             s2_v;
   logic [WIDTH-1:0] s2_g, s2_gp, s2_p;
   logic             s2_c0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v  <= 1'b0;
         s2_g  <= '0;
         s2_gp <= '0;
         s2_p  <= '0;
         s2_c0 <= 1'b0;
      end else if (adv) begin
         s2_v  <= s1_v;
         s2_g  <= up_g;
         s2_gp <= up_p;
         s2_p  <= s1_p;
         s2_c0 <= s1_c0;
      end
   end

   // ---------------- stage 3: down-sweep and sum ----------------------------
   // Level l fills position i (i >= 2^l, (i+1) mod 2^l == 2^(l-1)) from
   // i-2^(l-1), whose prefix already reaches bit 0, so only gray cells occur.
   logic [WIDTH-1:0] dn_g;
   logic [WIDTH:0]   carry;
   logic [WIDTH:0]   s_next;
   logic             ovf_next;
   always_comb begin
      dn_g = s2_g;
      for (int l = LVL - 1; l >= 1; l--) begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((i >= (1 << l)) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
               dn_g[i] = dn_g[i] | (s2_gp[i] & dn_g[i - (1 << (l - 1))]);
            end
         end
      end
      carry    = {dn_g, s2_c0};
      s_next   = {carry[WIDTH], s2_p ^ carry[WIDTH-1:0]};
      ovf_next = carry[WIDTH] ^ carry[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         s         <= '0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= s2_v;
         s         <= s_next;
         ovf       <= ovf_next;
      end
   end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_brent_kung_pipe_adder
//
// Self-checking bench for brent_kung_pipe_adder (WIDTH=8). Expected results
// ({ovf, s}) are queued when a beat is accepted and popped when a result is
// taken downstream. Covers reset state, latency, directed sums/overflow,
// back-pressure stall, mid-stream reset and a random valid/ready stream.
// Inputs change just after the falling edge; outputs are sampled 1 ns before
// the rising edge.
// -----------------------------------------------------------------------------
module tb_brent_kung_pipe_adder;

   localparam int WIDTH = 8;
   localparam int QW    = WIDTH + 2;

   // ---------------- clock / reset ------------------------------------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   s;
   logic             ovf;

   brent_kung_pipe_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef BKPA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .ovf       (ovf)
   );

   // ---------------- scoreboard state ---------------------------------------
   int              checks   = 0;
   int              failures = 0;
   logic [QW-1:0]   exp_q[$];
   logic [QW-1:0]   pend_exp;
   logic            acc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer add, overflow from operand/result signs.
   function automatic logic [QW-1:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic sb);
      logic [WIDTH-1:0] yy;
      logic             c;
      logic [WIDTH:0]   r;
      logic             v;
      yy = sb ? ~y : y;
      c  = sb ? 1'b1 : ci;
      r  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c};
      v  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      return {v, r};
   endfunction

   // ---------------- driver tasks -------------------------------------------
   task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb);
      a        = x;
      b        = y;
      cin      = ci;
      sub      = sb;
      in_valid = 1'b1;
      pend_exp = ref_sum(x, y, ci, sb);
   endtask

   task automatic drive_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic sb, input logic [QW-1:0] e);
      a        = x;
      b        = y;
      cin      = ci;
      sub      = sb;
      in_valid = 1'b1;
      pend_exp = e;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Sample 1 ns before the rising edge: record acceptance, score outputs.
   task automatic sample();
      logic [QW-1:0] e;
      #4;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(pend_exp);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_out_valid", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check_eq("result", {ovf, s}, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int limit);
      idle();
      out_ready = 1'b1;
      for (int n = 0; n < limit && exp_q.size() > 0; n++) begin
         sample();
         tick();
      end
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- watchdog -----------------------------------------------
   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ------------------------------------------
   initial begin
      logic [WIDTH-1:0] sa[4];
      logic [WIDTH-1:0] sbv[4];
      logic             sc[4];
      logic [QW-1:0]    first_exp;
      int               lat;
      int               idx;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      pend_exp  = '0;
      acc       = 1'b0;

      #1;
      check_eq("reset_out_valid", out_valid, 1'b0);
      check_eq("reset_s", s, 0);
      check_eq("reset_ovf", ovf, 1'b0);
      check_eq("reset_in_ready", in_ready, 1'b1);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Latency: 0xFF + 0x01 accepted on the first edge after reset.
      drive_exp(8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
      sample();
      check_eq("first_accept", acc, 1'b1);
      tick();
      idle();
      lat = 0;
      for (int n = 1; n <= 6 && lat == 0; n++) begin
         sample();
         if (out_valid) lat = n;
         tick();
      end
      check_eq("latency", lat, 3);

      // Signed overflow corners, back to back.
      drive_exp(8'h7F, 8'h00, 1'b1, 1'b0, 10'h280);
      sample();
      tick();
      drive_exp(8'h80, 8'h80, 1'b0, 1'b0, 10'h300);
      sample();
      tick();
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      sample();
      tick();
      drive(8'hAA, 8'h55, 1'b1, 1'b0);
      sample();
      tick();
      drain(20);

`ifdef BKPA_SUB_EN
      drive_exp(8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE);
      sample();
      tick();
      drive_exp(8'h07, 8'h05, 1'b0, 1'b1, 10'h102);
      sample();
      tick();
      drain(20);
`endif

      // Stall: 4 beats back to back, downstream stalls 5 cycles once the first
      // result appears; the 4th beat waits on in_ready.
      for (int k = 0; k < 4; k++) begin
         sa[k]  = WIDTH'($urandom_range(0, 255));
         sbv[k] = WIDTH'($urandom_range(0, 255));
         sc[k]  = 1'($urandom_range(0, 1));
      end
      first_exp = ref_sum(sa[0], sbv[0], sc[0], 1'b0);
      idx = 0;
      for (int cyc = 0; cyc < 30 && (idx < 4 || exp_q.size() > 0); cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 8);
         if (idx < 4) drive(sa[idx], sbv[idx], sc[idx], 1'b0);
         else         idle();
         sample();
         if (acc) idx++;
         if (cyc >= 3 && cyc < 8) begin
            check_eq("stall_in_ready", in_ready, 1'b0);
            check_eq("stall_out_valid", out_valid, 1'b1);
            check_eq("stall_hold", {ovf, s}, first_exp);
         end
         tick();
      end
      check_eq("stall_all_accepted", idx, 4);
      drain(20);

      // Reset with two beats in flight.
      out_ready = 1'b1;
      drive(8'h12, 8'h34, 1'b0, 1'b0);
      sample();
      tick();
      drive(8'h56, 8'h78, 1'b1, 1'b0);
      sample();
      tick();
      idle();
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_out_valid", out_valid, 1'b0);
      check_eq("async_rst_s", s, 0);
      check_eq("async_rst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         sample();
         check_eq("no_stale_after_rst", out_valid, 1'b0);
         tick();
      end

      // Random stream with random valid/ready.
      for (int n = 0; n < 3000; n++) begin
         logic sb_r;
         sb_r = 1'b0;
`ifdef BKPA_SUB_EN
         sb_r = 1'($urandom_range(0, 1));
`endif
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 7)
            drive(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), sb_r);
         else
            idle();
         sample();
         tick();
      end
      drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/brent_kung_pipe_adder.md
BRENT_KUNG_PIPE_ADDER -- requirements
Module: brent_kung_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width; power of two, 4..64.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 IN_VALID  input  1  operand beat present.
REQ-005 IN_READY  output  1  block accepts a beat this cycle.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 CIN  input  1  carry-in.
REQ-009 SUB  input  1  subtract select; present only when BKPA_SUB_EN is defined.
REQ-010 OUT_VALID  output  1  result beat present.
REQ-011 OUT_READY  input  1  downstream accepts the result.
REQ-012 S  output  WIDTH+1  sum; S[WIDTH] is carry-out.
REQ-013 OVF  output  1  two's-complement signed overflow of S[WIDTH-1:0].

Function
REQ-014 Datapath SHALL be a Brent-Kung prefix adder: per-bit G=A&B, P=A^B; up-sweep of log2(WIDTH) black/gray-cell levels; down-sweep of log2(WIDTH)-1 gray-cell levels.
REQ-015 Carry-in SHALL enter as bit -1 generate, so c[0]=CIN and c[i+1]=G[i:-1].
REQ-016 Sum bits SHALL be S[i]=P[i]^c[i] for i<WIDTH, and S[WIDTH]=c[WIDTH].
REQ-017 OVF SHALL equal c[WIDTH]^c[WIDTH-1].
REQ-018 Pipeline SHALL have exactly 3 register stages: stage 1 after G/P generation, stage 2 after up-sweep, stage 3 after down-sweep and sum XOR (output register).
REQ-019 Latency SHALL be 3 cycles from the accepting edge to OUT_VALID=1 with no stall.
REQ-020 Global advance signal adv = !OUT_VALID | OUT_READY; all stages and their valid bits SHALL load only when adv=1.
REQ-021 IN_READY SHALL equal adv (combinational from OUT_VALID and OUT_READY).
REQ-022 A beat is accepted when IN_VALID & IN_READY; a stage's valid bit SHALL load its predecessor's valid bit (stage 1 loads IN_VALID) on adv.
REQ-023 While OUT_VALID=1 and OUT_READY=0, S, OVF, OUT_VALID and every internal stage SHALL hold unchanged; no beat is lost or duplicated.
REQ-024 Bubbles (IN_VALID=0 accepted as invalid) SHALL propagate and yield OUT_VALID=0; throughput is one beat per cycle when OUT_READY=1.
REQ-025 Stage data registers SHALL capture only on adv; data contents with valid=0 are don't-care but SHALL never assert OUT_VALID.
REQ-026 Results SHALL emerge in acceptance order.

Reset
REQ-027 On RST=1 all valid bits, OUT_VALID, S and OVF SHALL clear to 0 immediately, regardless of CLK.
REQ-028 Beats in flight at reset SHALL be discarded; IN_READY=1 while RST is asserted.
REQ-029 First acceptance SHALL occur on the first rising CLK edge with RST=0.

Configuration
REQ-030 Macro BKPA_SUB_EN: when defined, SUB port exists; SUB=1 with an accepted beat SHALL register ~B as operand B and force c[0]=1, ignoring CIN; S[WIDTH]=1 means no borrow.
REQ-031 Without BKPA_SUB_EN: no SUB port; block always adds A+B+CIN.
REQ-032 SUB SHALL be sampled with A/B in stage 1 and travel with its beat.

Verification (WIDTH=8)
REQ-033 A=0xFF, B=0x01, CIN=0, OUT_READY=1 -> 3 cycles later OUT_VALID=1, S=0x100, OVF=0.
REQ-034 A=0x7F, B=0x00, CIN=1 -> S=0x080, OVF=1; A=0x80, B=0x80, CIN=0 -> S=0x100, OVF=1.
REQ-035 Back-to-back 4 beats, OUT_READY=0 from cycle 4 for 5 cycles -> IN_READY=0 during stall, S holds first result, then 4 results in order, none lost.
REQ-036 RST pulse asserted mid-stream with 2 beats in flight -> OUT_VALID=0 and S=0 asynchronously; no stale result after RST falls.
REQ-037 BKPA_SUB_EN defined: A=0x05, B=0x07, SUB=1, CIN=1 -> S=0x0FE, OVF=0; A=0x07, B=0x05, SUB=1 -> S=0x102.
REQ-038 Random 10k beats, random IN_VALID/OUT_READY, WIDTH in {4,8,32,64} -> every S equals reference A+B+CIN (or A-B), order preserved.
